// File: rtl/bp_me_cce_id_to_addr_sweep.sv
// Walks every cache-block address in the DRAM region that the address striping
// rule assigns to one CCE. This is the inverse of the address-to-CCE mapping.
// Directory init and flush sweeps use it.
module bp_me_cce_id_to_addr_sweep
  #(parameter int                       paddr_width_p     = 40
  , parameter int                       cce_id_width_p    = 6
  , parameter int                       num_cce_p         = 4
  , parameter int                       lce_sets_p        = 64
  , parameter int                       cce_block_width_p = 512
  , parameter logic [paddr_width_p-1:0] dram_base_addr_p  = 40'h00_8000_0000
  )
  (input  logic                      clk_i
  , input  logic                      reset_i
  , input  logic                      start_i
  , input  logic [cce_id_width_p-1:0] cce_id_i
  , output logic                      ready_o
  , output logic [paddr_width_p-1:0]  addr_o
  , output logic                      addr_v_o
  , input  logic                      addr_yumi_i
  , output logic                      done_o
  );

  localparam int block_offset_lp = $clog2(cce_block_width_p/8);
  localparam int lg_num_cce_lp   = $clog2(num_cce_p);
  localparam int sets_per_cce_lp = lce_sets_p/num_cce_p;
  localparam int idx_width_lp    = (sets_per_cce_lp > 1) ? $clog2(sets_per_cce_lp) : 1;

  // Keeps only the id bits that select a CCE. With one CCE the mask is zero,
  // so every block belongs to CCE 0.
  localparam logic [cce_id_width_p-1:0] cce_mask_lp  = cce_id_width_p'(num_cce_p-1);
  localparam logic [idx_width_lp-1:0]   last_idx_lp  = idx_width_lp'(sets_per_cce_lp-1);

  typedef enum logic [1:0] {IDLE_S, SWEEP_S, DONE_S} state_e;

  state_e                    state_q, state_d;
  logic [idx_width_lp-1:0]   idx_q, idx_d;
  logic [cce_id_width_p-1:0] cce_id_q, cce_id_d;
  logic [paddr_width_p-1:0]  block_num;

  // Block number interleaves the index above the CCE id bits.
  // Outside a sweep, the output rests at the region base.
  always_comb begin
    block_num = (paddr_width_p'(idx_q) << lg_num_cce_lp) | paddr_width_p'(cce_id_q);
    addr_o    = dram_base_addr_p;
    if (state_q == SWEEP_S)
      addr_o = dram_base_addr_p + (block_num << block_offset_lp);
  end

  // Next-state logic and handshake outputs for IDLE -> SWEEP -> DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cce_id_d = cce_id_q;
    ready_o  = 1'b0;
    addr_v_o = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      IDLE_S: begin
        ready_o = 1'b1;
        if (start_i) begin
          state_d  = SWEEP_S;
          idx_d    = '0;
          cce_id_d = cce_id_i & cce_mask_lp;
        end
      end
      SWEEP_S: begin
        addr_v_o = 1'b1;
        if (addr_yumi_i) begin
          if (idx_q == last_idx_lp)
            state_d = DONE_S;
          else
            idx_d = idx_q + idx_width_lp'(1);
        end
      end
      DONE_S: begin
        done_o  = 1'b1;
        state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  // State, index and captured id registers. Reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE_S;
      idx_q    <= '0;
      cce_id_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cce_id_q <= cce_id_d;
    end
  end

  // A consumer must not accept an address that is not being offered.
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(addr_yumi_i && !addr_v_o));
  end

endmodule

// File: tb/tb_bp_me_cce_id_to_addr_sweep.sv
// Directed bench for the CCE id to address sweep. It uses a default
// 4-CCE / 16-sets-per-CCE instance and a single-CCE / 4-set instance.
module tb_bp_me_cce_id_to_addr_sweep;

  localparam logic [39:0] BASE = 40'h00_8000_0000;

  logic        clk;
  logic        reset_i;
  logic        start_i, start1_i;
  logic [5:0]  cce_id_i, cce_id1_i;
  logic        addr_yumi_i, addr_yumi1_i;
  logic        ready_o, ready1_o;
  logic [39:0] addr_o, addr1_o;
  logic        addr_v_o, addr_v1_o;
  logic        done_o, done1_o;

  int vectors;
  int miscompares;

  bp_me_cce_id_to_addr_sweep dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .cce_id_i(cce_id_i),
    .ready_o(ready_o), .addr_o(addr_o), .addr_v_o(addr_v_o),
    .addr_yumi_i(addr_yumi_i), .done_o(done_o));

  bp_me_cce_id_to_addr_sweep #(.num_cce_p(1), .lce_sets_p(4)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start1_i), .cce_id_i(cce_id1_i),
    .ready_o(ready1_o), .addr_o(addr1_o), .addr_v_o(addr_v1_o),
    .addr_yumi_i(addr_yumi1_i), .done_o(done1_o));

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset state of both instances.
  task automatic test_reset();
    reset_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (ready_o !== 1'b1 || addr_v_o !== 1'b0 || done_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got ready=%b v=%b done=%b expected 1 0 0", ready_o, addr_v_o, done_o);
    end
    vectors++;
    if (addr_o !== BASE) begin
      miscompares++;
      $display("[TB] FAIL reset_addr: got %h expected %h", addr_o, BASE);
    end
    vectors++;
    if (ready1_o !== 1'b1 || addr_v1_o !== 1'b0 || addr1_o !== BASE) begin
      miscompares++;
      $display("[TB] FAIL reset_dut1: got ready=%b v=%b addr=%h expected 1 0 %h", ready1_o, addr_v1_o, addr1_o, BASE);
    end
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  // Full 16-address sweep on the default instance.
  // It can stall at one index and pulse a stray start at another.
  task automatic do_sweep(input int cce, input int stall_at, input int stall_len, input int inject_at);
    int k;
    int stalls;
    logic [39:0] expv;
    logic [39:0] prev;
    logic [1:0]  owner;
    k = 0;
    stalls = 0;
    prev = '0;
    @(negedge clk);
    start_i = 1'b1;
    cce_id_i = 6'(cce);
    addr_yumi_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    cce_id_i = 6'd1;
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sweep_ready: got %b expected 0", ready_o);
    end
    for (int cyc = 0; cyc < 200 && k < 16; cyc++) begin
      expv = BASE + (((40'(k) << 2) | 40'(cce)) << 6);
      vectors++;
      if (addr_v_o !== 1'b1 || addr_o !== expv) begin
        miscompares++;
        $display("[TB] FAIL sweep_addr cce=%0d k=%0d: got v=%b addr=%h expected v=1 addr=%h", cce, k, addr_v_o, addr_o, expv);
      end
      owner = addr_o[6 +: 2];
      vectors++;
      if (owner !== 2'(cce) || addr_o < BASE || (k > 0 && stalls == 0 && addr_o <= prev)) begin
        miscompares++;
        $display("[TB] FAIL scoreboard cce=%0d k=%0d: got addr=%h owner=%0d expected owner=%0d above %h", cce, k, addr_o, owner, cce, prev);
      end
      start_i = (k == inject_at) ? 1'b1 : 1'b0;
      if (k == stall_at && stalls < stall_len) begin
        addr_yumi_i = 1'b0;
        stalls++;
      end else begin
        addr_yumi_i = 1'b1;
        prev = addr_o;
        stalls = 0;
        if (k == stall_at) stall_at = -1;
        k++;
      end
      @(negedge clk);
    end
    addr_yumi_i = 1'b0;
    start_i = 1'b0;
    vectors++;
    if (k != 16) begin
      miscompares++;
      $display("[TB] FAIL sweep_timeout: got %0d accepts expected 16", k);
    end
    vectors++;
    if (done_o !== 1'b1 || addr_v_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_pulse cce=%0d: got done=%b v=%b expected 1 0", cce, done_o, addr_v_o);
    end
    @(negedge clk);
    vectors++;
    if (done_o !== 1'b0 || ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL done_return cce=%0d: got done=%b ready=%b expected 0 1", cce, done_o, ready_o);
    end
  endtask

  // Basic sweep for CCE 2 with no backpressure.
  task automatic test_basic_sweep();
    do_sweep(2, -1, 0, -1);
  endtask

  // Stall for five cycles at index 3. The address must hold during the stall.
  task automatic test_backpressure();
    do_sweep(2, 3, 5, -1);
  endtask

  // A stray start with a different id during a CCE 3 sweep must be ignored.
  task automatic test_ignore_start();
    do_sweep(3, -1, 0, 5);
  endtask

  // Back-to-back sweeps for CCE 1 and then CCE 0.
  task automatic test_back_to_back();
    do_sweep(1, -1, 0, -1);
    do_sweep(0, -1, 0, -1);
  endtask

  // Reset at index 7 aborts the sweep with no done pulse.
  // A following sweep starts from the base address again.
  task automatic test_reset_mid_sweep();
    logic [39:0] expv;
    @(negedge clk);
    start_i = 1'b1;
    cce_id_i = 6'd2;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      addr_yumi_i = 1'b1;
      @(negedge clk);
    end
    expv = 40'h00_8000_0780;
    vectors++;
    if (addr_o !== expv || addr_v_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_idx7: got v=%b addr=%h expected v=1 addr=%h", addr_v_o, addr_o, expv);
    end
    reset_i = 1'b1;
    addr_yumi_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (addr_v_o !== 1'b0 || ready_o !== 1'b1 || done_o !== 1'b0 || addr_o !== BASE) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got v=%b ready=%b done=%b addr=%h expected 0 1 0 %h", addr_v_o, ready_o, done_o, addr_o, BASE);
    end
    reset_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (done_o !== 1'b0 || ready_o !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL mid_no_done: got done=%b ready=%b expected 0 1", done_o, ready_o);
      end
    end
    do_sweep(0, -1, 0, -1);
  endtask

  // Single-CCE, four-set instance. Blocks run contiguously from the base.
  task automatic test_single_cce();
    int k;
    logic [39:0] expv;
    k = 0;
    @(negedge clk);
    start1_i = 1'b1;
    cce_id1_i = 6'd0;
    @(negedge clk);
    start1_i = 1'b0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      expv = BASE + 40'(k) * 40'h40;
      vectors++;
      if (addr_v1_o !== 1'b1 || addr1_o !== expv) begin
        miscompares++;
        $display("[TB] FAIL single_addr k=%0d: got v=%b addr=%h expected v=1 addr=%h", k, addr_v1_o, addr1_o, expv);
      end
      addr_yumi1_i = 1'b1;
      k++;
      @(negedge clk);
    end
    addr_yumi1_i = 1'b0;
    vectors++;
    if (done1_o !== 1'b1 || addr_v1_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_done: got done=%b v=%b expected 1 0", done1_o, addr_v1_o);
    end
    @(negedge clk);
    vectors++;
    if (done1_o !== 1'b0 || ready1_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_return: got done=%b ready=%b expected 0 1", done1_o, ready1_o);
    end
  endtask

  // Runs the scenarios in order and prints the summary.
  initial begin
    vectors = 0;
    miscompares = 0;
    reset_i = 1'b1;
    start_i = 1'b0;
    start1_i = 1'b0;
    cce_id_i = '0;
    cce_id1_i = '0;
    addr_yumi_i = 1'b0;
    addr_yumi1_i = 1'b0;
    test_reset();
    test_basic_sweep();
    test_backpressure();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_sweep();
    test_single_cce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_me_cce_id_to_addr_sweep.md
BP_ME_CCE_ID_TO_ADDR_SWEEP -- requirements
Module: bp_me_cce_id_to_addr_sweep

Purpose: inverse of the address-to-CCE striping. Given a CCE id, sequentially emit every cache-block address in the DRAM region that the DRAM striping rule assigns to that CCE. Used for directory init and flush sweeps.

Interface
REQ-001 SHALL have parameter paddr_width_p, 40, physical address width in bits.
REQ-002 SHALL have parameter cce_id_width_p, 6, CCE id width in bits.
REQ-003 SHALL have parameter num_cce_p, 4, number of CCEs; must be a power of two and at least 1.
REQ-004 SHALL have parameter lce_sets_p, 64, sets per LCE; must be a power of two and at least num_cce_p.
REQ-005 SHALL have parameter cce_block_width_p, 512, cache block width in bits.
REQ-006 SHALL have parameter dram_base_addr_p, 40'h00_8000_0000, DRAM region base; must be block aligned.
REQ-007 SHALL have port clk_i, input, 1, the single clock.
REQ-008 SHALL have port reset_i, input, 1; reset is synchronous and active-high.
REQ-009 SHALL have port start_i, input, 1, sweep request; it is sampled only in IDLE.
REQ-010 SHALL have port cce_id_i, input, cce_id_width_p, target CCE id; it is captured on the accepted start.
REQ-011 SHALL have port ready_o, output, 1, high only in IDLE.
REQ-012 SHALL have port addr_o, output, paddr_width_p, the current block address.
REQ-013 SHALL have port addr_v_o, output, 1, addr_o valid.
REQ-014 SHALL have port addr_yumi_i, input, 1, consumer accepts addr_o; it is legal only while addr_v_o is high.
REQ-015 SHALL have port done_o, output, 1, one-cycle pulse after the last address is accepted.

Function
REQ-016 Derived constants SHALL be:
- block_offset = log2(cce_block_width_p/8)
- lg_num_cce = log2(num_cce_p), with 0 permitted
- sets_per_cce = lce_sets_p/num_cce_p
REQ-017 The owner rule SHALL be: a DRAM block belongs to CCE c iff paddr[block_offset +: lg_num_cce] == c; with num_cce_p == 1, every block belongs to CCE 0.
REQ-018 The FSM SHALL have three states: IDLE, SWEEP, DONE.
REQ-019 IDLE -> SWEEP SHALL occur when start_i is high; the block captures cce_id_i modulo num_cce_p (the low lg_num_cce bits) and clears the index counter to 0.
REQ-020 In SWEEP, addr_v_o SHALL be 1 and addr_o = dram_base_addr_p + (((idx << lg_num_cce) | cce_id_r) << block_offset), zero-extended to paddr_width_p.
REQ-021 The index counter SHALL advance only on a cycle where addr_v_o and addr_yumi_i are both high.
REQ-022 addr_o SHALL hold stable while addr_v_o is high and addr_yumi_i is low.
REQ-023 If idx == sets_per_cce-1 when addr_yumi_i is accepted, the FSM SHALL move to DONE and SHALL NOT wrap idx.
REQ-024 DONE SHALL assert done_o for exactly one cycle and then return to IDLE unconditionally.
REQ-025 Exactly sets_per_cce addresses SHALL be emitted per sweep, in strictly increasing order.
REQ-026 Latency: the first addr_v_o SHALL appear in the cycle after start is accepted; with addr_yumi_i held high, the sweep SHALL take sets_per_cce cycles, with done_o on the following cycle.
REQ-027 start_i SHALL be ignored outside IDLE, and cce_id_i changes during a sweep SHALL have no effect.
REQ-028 The index counter SHALL be log2(sets_per_cce) bits wide, with a minimum width of 1.
REQ-029 addr_yumi_i asserted while addr_v_o is low SHALL be ignored; the design SHALL include an assertion that flags it.

Reset
REQ-030 When reset_i is high at a clock edge, the state SHALL become IDLE, idx 0, and cce_id_r 0.
REQ-031 During and after reset: ready_o = 1, addr_v_o = 0, done_o = 0, addr_o = dram_base_addr_p.
REQ-032 Reset asserted mid-SWEEP SHALL abort the sweep with no done_o pulse; the next start SHALL begin again from idx 0.

Verification
REQ-033 Defaults, cce_id_i=2, start, addr_yumi_i tied high:
- addresses 0x80000080, 0x80000180, ..., 0x80000F80 (16 total, stride 0x100)
- done_o pulses on the cycle after the 16th acceptance.
REQ-034 Backpressure: addr_yumi_i low for 5 cycles at idx 3 -> addr_o holds 0x80000380 (cce 2) throughout, and no address is skipped or duplicated.
REQ-035 num_cce_p=1, lce_sets_p=4, cce_id_i=0 -> 0x80000000, 0x80000040, 0x80000080, 0x800000C0, then done_o.
REQ-036 start_i pulsed with cce_id_i=1 during an active sweep for cce 3 -> ignored, and the sweep for cce 3 completes unchanged.
REQ-037 reset_i asserted at idx 7 -> the next cycle shows addr_v_o=0 and ready_o=1 with no done_o; a new start with cce 0 begins at 0x80000000.
REQ-038 A scoreboard SHALL check that every emitted address maps back to cce_id_r under the forward striping rule and lies at or above dram_base_addr_p.
